// File: rtl/voice_allocator_pkg.sv
// Shared types for the voice allocator: FSM state, search action and age-width helper.
package synth_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SEARCH = 2'd1,
        ST_APPLY  = 2'd2
    } state_e;

    typedef enum logic [2:0] {
        ACT_RETRIGGER = 3'd0,
        ACT_FREE      = 3'd1,
        ACT_STEAL     = 3'd2,
        ACT_DROP      = 3'd3,
        ACT_OFF       = 3'd4,
        ACT_NONE      = 3'd5
    } action_e;

    function automatic int age_width(input int num_voices);
        return (num_voices <= 2) ? 1 : $clog2(num_voices);
    endfunction

endpackage

// File: rtl/voice_allocator_if.sv
// Command and voice-bank bundle between the control front-end and the allocator.
interface voice_allocator_if #(
    parameter int NUM_VOICES = 4,
    parameter int INCR_WIDTH = 8,
    parameter int KEY_WIDTH  = 7
);
    logic                             cmd_valid;
    logic                             cmd_ready;
    logic                             cmd_on;
    logic [KEY_WIDTH-1:0]             cmd_key;
    logic [INCR_WIDTH-1:0]            cmd_incr;
    logic [NUM_VOICES-1:0]            voice_gate;
    logic [NUM_VOICES*INCR_WIDTH-1:0] voice_incr;
    logic [NUM_VOICES*KEY_WIDTH-1:0]  voice_key;
    logic                             dropped;

    modport master (
        output cmd_valid, cmd_on, cmd_key, cmd_incr,
        input  cmd_ready, voice_gate, voice_incr, voice_key, dropped
    );

    modport slave (
        input  cmd_valid, cmd_on, cmd_key, cmd_incr,
        output cmd_ready, voice_gate, voice_incr, voice_key, dropped
    );
endinterface

// File: rtl/voice_allocator_pick.sv
// voice_pick: combinational search for key match, first free voice and oldest voice.
module voice_pick
    import synth_pkg::*;
#(
    parameter int NV = 4,
    parameter int KW = 7,
    parameter int AW = age_width(NV)
) (
    input  logic [NV-1:0]         gate_i,
    input  logic [NV-1:0][KW-1:0] key_i,
    input  logic [NV-1:0][AW-1:0] age_i,
    input  logic [KW-1:0]         cmd_key_i,
    output logic [AW-1:0]         match_idx_o,
    output logic                  match_found_o,
    output logic [AW-1:0]         free_idx_o,
    output logic                  free_found_o,
    output logic [AW-1:0]         oldest_idx_o
);

    // Scan from the top down so the lowest matching index wins.
    always_comb begin
        match_idx_o   = '0;
        match_found_o = 1'b0;
        free_idx_o    = '0;
        free_found_o  = 1'b0;
        oldest_idx_o  = '0;
        for (int v = NV - 1; v >= 0; v--) begin
            if (gate_i[v] && (key_i[v] == cmd_key_i)) begin
                match_found_o = 1'b1;
                match_idx_o   = AW'(v);
            end
            if (!gate_i[v]) begin
                free_found_o = 1'b1;
                free_idx_o   = AW'(v);
            end
            if (age_i[v] == AW'(NV - 1)) begin
                oldest_idx_o = AW'(v);
            end
        end
    end

endmodule

// File: rtl/voice_allocator.sv
// Note-on/note-off voice allocator with LRU ages; VOICE_STEAL_EN enables stealing
// the oldest voice when the bank is full, otherwise the note-on is dropped.
module voice_allocator
    import synth_pkg::*;
#(
    parameter int NUM_VOICES = 4,
    parameter int INCR_WIDTH = 8,
    parameter int KEY_WIDTH  = 7
) (
    input  logic clk_i,
    input  logic rst_ni,
    voice_allocator_if.slave bus
);

    localparam int AW = age_width(NUM_VOICES);

    localparam logic [1:0] S_IDLE   = ST_IDLE;
    localparam logic [1:0] S_SEARCH = ST_SEARCH;
    localparam logic [1:0] S_APPLY  = ST_APPLY;

    logic [1:0]                             state_q, state_d;
    logic                                   on_q;
    logic [KEY_WIDTH-1:0]                   key_q;
    logic [INCR_WIDTH-1:0]                  incr_q;
    action_e                                act_q;
    logic [AW-1:0]                          tgt_q;
    logic [NUM_VOICES-1:0]                  gate_q;
    logic [NUM_VOICES-1:0][INCR_WIDTH-1:0]  vincr_q;
    logic [NUM_VOICES-1:0][KEY_WIDTH-1:0]   vkey_q;
    logic [NUM_VOICES-1:0][AW-1:0]          age_q;
    logic                                   dropped_q;

    logic [AW-1:0] match_idx, free_idx, oldest_idx;
    logic          match_found, free_found;

    voice_pick #(
        .NV (NUM_VOICES),
        .KW (KEY_WIDTH),
        .AW (AW)
    ) u_pick (
        .gate_i        (gate_q),
        .key_i         (vkey_q),
        .age_i         (age_q),
        .cmd_key_i     (key_q),
        .match_idx_o   (match_idx),
        .match_found_o (match_found),
        .free_idx_o    (free_idx),
        .free_found_o  (free_found),
        .oldest_idx_o  (oldest_idx)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:   if (bus.cmd_valid) state_d = S_SEARCH;
            S_SEARCH: state_d = S_APPLY;
            default:  state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= S_IDLE;
            on_q      <= 1'b0;
            key_q     <= '0;
            incr_q    <= '0;
            act_q     <= ACT_NONE;
            tgt_q     <= '0;
            gate_q    <= '0;
            vincr_q   <= '0;
            vkey_q    <= '0;
            dropped_q <= 1'b0;
            for (int v = 0; v < NUM_VOICES; v++) begin
                age_q[v] <= AW'(v);
            end
        end else begin
            state_q   <= state_d;
            dropped_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (bus.cmd_valid) begin
                        on_q   <= bus.cmd_on;
                        key_q  <= bus.cmd_key;
                        incr_q <= bus.cmd_incr;
                    end
                end
                S_SEARCH: begin
                    if (on_q) begin
                        if (match_found) begin
                            act_q <= ACT_RETRIGGER;
                            tgt_q <= match_idx;
                        end else if (free_found) begin
                            act_q <= ACT_FREE;
                            tgt_q <= free_idx;
                        end else begin
`ifdef VOICE_STEAL_EN
                            act_q <= ACT_STEAL;
                            tgt_q <= oldest_idx;
`else
                            act_q <= ACT_DROP;
                            tgt_q <= '0;
`endif
                        end
                    end else begin
                        act_q <= match_found ? ACT_OFF : ACT_NONE;
                        tgt_q <= match_idx;
                    end
                end
                S_APPLY: begin
                    case (act_q)
                        ACT_RETRIGGER, ACT_FREE, ACT_STEAL: begin
                            gate_q[tgt_q]  <= 1'b1;
                            vincr_q[tgt_q] <= incr_q;
                            vkey_q[tgt_q]  <= key_q;
                            // Move the target to the front; everything younger ages by one.
                            for (int v = 0; v < NUM_VOICES; v++) begin
                                if (AW'(v) == tgt_q) begin
                                    age_q[v] <= '0;
                                end else if (age_q[v] < age_q[tgt_q]) begin
                                    age_q[v] <= age_q[v] + 1'b1;
                                end
                            end
                        end
                        ACT_OFF:  gate_q[tgt_q] <= 1'b0;
                        ACT_DROP: dropped_q <= 1'b1;
                        default:  ;
                    endcase
                end
                default: ;
            endcase
        end
    end

    assign bus.cmd_ready  = (state_q == S_IDLE);
    assign bus.voice_gate = gate_q;
    assign bus.voice_incr = vincr_q;
    assign bus.voice_key  = vkey_q;
    assign bus.dropped    = dropped_q;

    // oldest_idx is only consumed when stealing is built in.
    logic unused_oldest;
    assign unused_oldest = ^oldest_idx;

endmodule

// File: tb/tb_voice_allocator.sv
// Self-checking bench for voice_allocator: directed test-plan scenarios plus random commands
// checked against a recency-list reference model.
module tb_voice_allocator;

    localparam int NV = 4;
    localparam int IW = 8;
    localparam int KW = 7;

    logic clk = 1'b0;
    logic rst_n;
    int   tests = 0;
    int   fails = 0;

    always #5 clk = ~clk;

    voice_allocator_if #(.NUM_VOICES(NV), .INCR_WIDTH(IW), .KEY_WIDTH(KW)) bus ();

    voice_allocator #(.NUM_VOICES(NV), .INCR_WIDTH(IW), .KEY_WIDTH(KW)) dut (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .bus    (bus)
    );

    // Reference model: voice contents plus a most-recent-first list of voice indices.
    logic          m_gate [NV];
    logic [IW-1:0] m_incr [NV];
    logic [KW-1:0] m_key  [NV];
    int            recency[$];
    logic          m_drop;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        if (obs !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic void model_reset();
        recency.delete();
        for (int v = 0; v < NV; v++) begin
            m_gate[v] = 1'b0;
            m_incr[v] = '0;
            m_key[v]  = '0;
            recency.push_back(v);
        end
        m_drop = 1'b0;
    endfunction

    function automatic void model_cmd(input logic on, input logic [KW-1:0] key,
                                      input logic [IW-1:0] incr);
        int t = -1;
        int pos = 0;
        m_drop = 1'b0;
        for (int v = NV - 1; v >= 0; v--)
            if (m_gate[v] && m_key[v] == key) t = v;
        if (!on) begin
            if (t >= 0) m_gate[t] = 1'b0;
            return;
        end
        if (t < 0)
            for (int v = NV - 1; v >= 0; v--)
                if (!m_gate[v]) t = v;
        if (t < 0) begin
`ifdef VOICE_STEAL_EN
            t = recency[recency.size() - 1];
`else
            m_drop = 1'b1;
            return;
`endif
        end
        m_gate[t] = 1'b1;
        m_incr[t] = incr;
        m_key[t]  = key;
        foreach (recency[i]) if (recency[i] == t) pos = i;
        recency.delete(pos);
        recency.push_front(t);
    endfunction

    function automatic logic [NV-1:0] exp_gate();
        logic [NV-1:0] r;
        for (int v = 0; v < NV; v++) r[v] = m_gate[v];
        return r;
    endfunction

    function automatic logic [NV*IW-1:0] exp_incr();
        logic [NV*IW-1:0] r;
        for (int v = 0; v < NV; v++) r[v*IW +: IW] = m_incr[v];
        return r;
    endfunction

    function automatic logic [NV*KW-1:0] exp_key();
        logic [NV*KW-1:0] r;
        for (int v = 0; v < NV; v++) r[v*KW +: KW] = m_key[v];
        return r;
    endfunction

    task automatic check_outputs(input string tag);
        chk({tag, "_gate"}, 64'(bus.voice_gate), 64'(exp_gate()));
        chk({tag, "_incr"}, 64'(bus.voice_incr), 64'(exp_incr()));
        chk({tag, "_key"},  64'(bus.voice_key),  64'(exp_key()));
    endtask

    task automatic send_cmd(input logic on, input logic [KW-1:0] key, input logic [IW-1:0] incr);
        logic [NV-1:0]    g0;
        logic [NV*IW-1:0] i0;
        logic [NV*KW-1:0] k0;
        @(negedge clk);
        chk("ready_idle", 64'(bus.cmd_ready), 64'd1);
        bus.cmd_valid = 1'b1;
        bus.cmd_on    = on;
        bus.cmd_key   = key;
        bus.cmd_incr  = incr;
        @(posedge clk);
        #1;
        bus.cmd_valid = 1'b0;
        bus.cmd_on    = 1'($urandom);
        bus.cmd_key   = KW'($urandom);
        bus.cmd_incr  = IW'($urandom);
        chk("ready_busy", 64'(bus.cmd_ready), 64'd0);
        g0 = exp_gate();
        i0 = exp_incr();
        k0 = exp_key();
        @(posedge clk);
        #1;
        chk("gate_e1", 64'(bus.voice_gate), 64'(g0));
        chk("incr_e1", 64'(bus.voice_incr), 64'(i0));
        chk("key_e1",  64'(bus.voice_key),  64'(k0));
        model_cmd(on, key, incr);
        @(posedge clk);
        #1;
        check_outputs("e2");
        chk("dropped_e2", 64'(bus.dropped), 64'(m_drop));
        chk("ready_e2", 64'(bus.cmd_ready), 64'd1);
        @(posedge clk);
        #1;
        chk("dropped_clear", 64'(bus.dropped), 64'd0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        bus.cmd_valid = 1'b0;
        #2;
        chk("rst_ready", 64'(bus.cmd_ready), 64'd1);
        chk("rst_gate",  64'(bus.voice_gate), 64'd0);
        chk("rst_incr",  64'(bus.voice_incr), 64'd0);
        chk("rst_key",   64'(bus.voice_key),  64'd0);
        chk("rst_drop",  64'(bus.dropped),    64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
    endtask

    initial begin
        int accepts;
        logic on;
        rst_n         = 1'b0;
        bus.cmd_valid = 1'b0;
        bus.cmd_on    = 1'b0;
        bus.cmd_key   = '0;
        bus.cmd_incr  = '0;
        model_reset();
        repeat (2) @(posedge clk);
        do_reset();

        // Fill, release tail, reuse of freed voice, retrigger, full bank.
        send_cmd(1'b1, 7'd60, 8'h10);
        send_cmd(1'b1, 7'd62, 8'h12);
        send_cmd(1'b1, 7'd64, 8'h14);
        send_cmd(1'b1, 7'd67, 8'h18);
        chk("fill_gate", 64'(bus.voice_gate), 64'hF);
        send_cmd(1'b0, 7'd62, 8'h00);
        chk("off_gate", 64'(bus.voice_gate), 64'hD);
        chk("off_tail", 64'(bus.voice_incr[1*IW +: IW]), 64'h12);
        send_cmd(1'b1, 7'd70, 8'h22);
        chk("free_v1_key", 64'(bus.voice_key[1*KW +: KW]), 64'd70);
        send_cmd(1'b1, 7'd64, 8'h20);
        chk("retrig_v2", 64'(bus.voice_incr[2*IW +: IW]), 64'h20);
        send_cmd(1'b1, 7'd72, 8'h30);
        send_cmd(1'b0, 7'd99, 8'h00);

        // Held valid: one accept per three cycles.
        do_reset();
        @(negedge clk);
        bus.cmd_valid = 1'b1;
        bus.cmd_on    = 1'b1;
        bus.cmd_key   = 7'd50;
        bus.cmd_incr  = 8'h44;
        accepts = 0;
        for (int c = 0; c < 9; c++) begin
            if (bus.cmd_ready) begin
                accepts++;
                model_cmd(1'b1, 7'd50, 8'h44);
            end
            @(negedge clk);
        end
        bus.cmd_valid = 1'b0;
        chk("hold_accepts", 64'(accepts), 64'd3);
        repeat (3) @(negedge clk);
        check_outputs("hold");

        // Reset during SEARCH aborts the command.
        @(negedge clk);
        bus.cmd_valid = 1'b1;
        bus.cmd_on    = 1'b1;
        bus.cmd_key   = 7'd61;
        bus.cmd_incr  = 8'h55;
        @(posedge clk);
        #1;
        bus.cmd_valid = 1'b0;
        rst_n = 1'b0;
        #2;
        chk("midrst_ready", 64'(bus.cmd_ready), 64'd1);
        chk("midrst_gate",  64'(bus.voice_gate), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        repeat (4) @(negedge clk);
        check_outputs("midrst_after");
        chk("midrst_drop", 64'(bus.dropped), 64'd0);

        // Random commands over a narrow key range to exercise retrigger, off, full bank.
        for (int n = 0; n < 80; n++) begin
            on = ($urandom_range(0, 9) < 6);
            send_cmd(on, KW'($urandom_range(60, 66)), IW'($urandom));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
